aes_iter_core: RTL and testbench
================================

# aes_iter_core

Iterative AES encryption core: one AES round per clock, with the key schedule expanded on the fly. It replaces the fully unrolled combinational encryptor wherever area matters more than throughput. It adds a valid/ready handshake on input and output, registered state, and a parametrised key length (AES-128 or AES-256). It sits between a block source (DMA or stream framer) and a ciphertext sink that may apply backpressure.

## Interface
- KEY_BITS, 128, key length; legal values 128 or 256. Number of rounds Nr = 10 or 14. Any other value fails elaboration.
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  plaintext and key present
- in_ready  out  1  core can accept a block this cycle
- in_data  in  128  plaintext block, FIPS-197 byte order (byte 0 = bits [127:120])
- in_key  in  KEY_BITS  cipher key, FIPS-197 order (first key byte = MSB)
- out_valid  out  1  ciphertext held on out_data
- out_ready  in  1  sink accepts ciphertext this cycle
- out_data  out  128  ciphertext block
- busy  out  1  high while rounds are in progress (state RUN)

## Operation
- States:
  - IDLE: in_ready = 1.
  - RUN: round counter rnd = 1..Nr.
  - DONE: out_valid = 1.
- IDLE, in_valid & in_ready:
  - state_reg <= in_data ^ in_key[KEY_BITS-1 -: 128].
  - Key registers capture in_key.
  - rnd <= 1; go to RUN.
- RUN, each cycle, applies round rnd using round key rk[rnd] from the current key registers:
  - rnd < Nr: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - rnd = Nr: final round with no MixColumns. Result is loaded into out_data; go to DONE.
  - Key registers advance one key-schedule step per cycle.
  - AES-128: 128-bit window, Rcon index rnd.
  - AES-256: 256-bit window of 8 words. Odd/even step alternates RotWord+SubWord+Rcon with SubWord only, per FIPS-197 for Nk=8.
- DONE:
  - out_data and out_valid are held stable until out_ready.
  - out_ready & !in_valid: go to IDLE.
  - out_ready & in_valid: accept the new block in the same cycle and go directly to RUN. Back-to-back operation; in_ready = out_ready in DONE.
- in_data and in_key are sampled only on the accept edge. Changes at any other time are ignored.
- The S-box is combinational. Use 16 instances for the state plus 4 for the key schedule (shared across AES-256 alternate steps).
- Decryption is out of scope.

## Timing
- Reset values: in_ready = 0 during the reset cycle, then 1 (IDLE). out_valid = 0, busy = 0, out_data = 0. Internal state and key registers are 0.
- Latency: accept on edge T gives out_valid = 1 after edge T+Nr. That is 10 cycles for AES-128 and 14 for AES-256.
- Throughput:
  - With out_ready held high: one block per Nr+1 cycles if in_valid is held (DONE→RUN direct).
  - One block per Nr+2 cycles via IDLE.
- in_ready is 0 throughout RUN. in_valid during RUN is not accepted and must be held by the source.
- The output handshake completes on the edge where out_valid & out_ready are both 1. out_data may change only after that edge.
- rst asserted in any state (including mid-RUN or DONE with a stalled sink):
  - Next edge gives IDLE, out_valid = 0, busy = 0.
  - The in-flight block is discarded and no partial ciphertext is emitted.
- rst has priority over a simultaneous in_valid; no block is accepted on a reset edge.
- The critical path is one round plus one key-schedule step, both combinational from registers.

## Test plan
- AES-128: in_data 00112233445566778899aabbccddeeff, in_key 000102030405060708090a0b0c0d0e0f -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid rising exactly 10 cycles after accept, busy high for 10 cycles.
- AES-256 (KEY_BITS=256): same plaintext, in_key 000102…1e1f -> 8ea2b7ca516745bfeafc49904b496089 after exactly 14 cycles.
- Backpressure: AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734. Hold out_ready = 0 for 20 cycles -> 3925841d02dc09fbdc118597196a0b32 stable, in_ready = 0 throughout. Then out_ready = 1 for one cycle -> completes once.
- Back-to-back: in_valid held with two blocks and out_ready = 1 -> second block accepted on the same edge the first is consumed, second out_valid 11 cycles after the first. Both ciphertexts correct.
- Input isolation: change in_key and in_data every cycle during RUN -> ciphertext matches the values sampled at accept.
- Reset mid-operation: assert rst at round 5 -> next cycle out_valid = 0, busy = 0, in_ready = 1. A fresh vector then produces the correct result with no spurious output.

Source files
------------

// File: rtl/aes_iter_core.sv
// Purpose : iterative AES-128/256 encryptor, one round per clock, key schedule expanded on the fly.
// Latency : block accepted on edge T shows out_valid after edge T+Nr (10 or 14).
// Backpressure: ciphertext held in DONE until out_ready; in_ready low while rounds run.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the inverse for nonzero x and maps 0 to 0, as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x14  = gmul(x12, x2);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        return gmul(x240, x14);
    endfunction

    logic [7:0] inv;

    assign inv = ginv(a);
    assign s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);
    localparam int NR = (KEY_BITS == 256) ? 14 : 10;

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              st_q, st_d;
    logic [127:0]        state_q;
    logic [KEY_BITS-1:0] key_q, key_next;
    logic [3:0]          rnd_q;
    logic [127:0]        out_data_q;
    logic [127:0]        rk, sb_flat, shifted, mixed;
    logic [31:0]         sbk_in, sbk_out;
    logic [7:0]          a0, a1, a2, a3;
    logic                accept, last_rnd;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign accept   = in_valid & in_ready;
    assign last_rnd = (rnd_q == 4'(NR));
    assign out_data = out_data_q;

    // 16 state S-boxes feeding SubBytes
    for (genvar i = 0; i < 16; i++) begin : g_sbox_state
        aes_sbox u_sbox (.a(state_q[127-8*i -: 8]), .s(sb_flat[127-8*i -: 8]));
    end

    // 4 key-schedule S-boxes (SubWord), shared by both AES-256 step flavours
    for (genvar i = 0; i < 4; i++) begin : g_sbox_key
        aes_sbox u_sbox (.a(sbk_in[31-8*i -: 8]), .s(sbk_out[31-8*i -: 8]));
    end

    if (KEY_BITS == 256) begin : g_key256
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, n0, n1, n2, n3, temp;
        logic [3:0]  rc_idx;
        // window holds w[4(r-1) .. 4(r-1)+7]; its low half is rk[r]
        assign {w0, w1, w2, w3, w4, w5, w6, w7} = key_q;
        assign rc_idx   = (rnd_q + 4'd1) >> 1;
        assign sbk_in   = rnd_q[0] ? {w7[23:0], w7[31:24]} : w7;
        assign temp     = sbk_out ^ (rnd_q[0] ? {rcon(rc_idx), 24'h0} : 32'h0);
        assign n0       = w0 ^ temp;
        assign n1       = w1 ^ n0;
        assign n2       = w2 ^ n1;
        assign n3       = w3 ^ n2;
        assign rk       = {w4, w5, w6, w7};
        assign key_next = {w4, w5, w6, w7, n0, n1, n2, n3};
    end else begin : g_key128
        logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3, temp;
        // window holds rk[r-1]; this round's key is the freshly expanded one
        assign {w0, w1, w2, w3} = key_q;
        assign sbk_in   = {w3[23:0], w3[31:24]};
        assign temp     = sbk_out ^ {rcon(rnd_q), 24'h0};
        assign n0       = w0 ^ temp;
        assign n1       = w1 ^ n0;
        assign n2       = w2 ^ n1;
        assign n3       = w3 ^ n2;
        assign rk       = {n0, n1, n2, n3};
        assign key_next = rk;
    end

    // ShiftRows then MixColumns, one column at a time
    always_comb begin
        shifted = '0;
        mixed   = '0;
        a0 = 8'h00;
        a1 = 8'h00;
        a2 = 8'h00;
        a3 = 8'h00;
        for (int c = 0; c < 4; c++) begin
            a0 = sb_flat[127-8*(4*c)               -: 8];
            a1 = sb_flat[127-8*(4*((c+1)%4) + 1)   -: 8];
            a2 = sb_flat[127-8*(4*((c+2)%4) + 2)   -: 8];
            a3 = sb_flat[127-8*(4*((c+3)%4) + 3)   -: 8];
            shifted[127-32*c -: 32] = {a0, a1, a2, a3};
            mixed[127-32*c -: 32]   = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                       xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
    end

    // control: next state and handshake outputs; reset masks in_ready so nothing is accepted
    always_comb begin
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (st_q)
            S_IDLE: begin
                in_ready = !rst;
                if (in_valid) st_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_rnd) st_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !rst;
                if (out_ready) st_d = in_valid ? S_RUN : S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) st_q <= S_IDLE;
        else     st_q <= st_d;
    end

    // datapath: load on accept, one round per cycle in RUN, capture result on the last round
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= '0;
            key_q      <= '0;
            rnd_q      <= '0;
            out_data_q <= '0;
        end else if (accept) begin
            state_q <= in_data ^ in_key[KEY_BITS-1 -: 128];
            key_q   <= in_key;
            rnd_q   <= 4'd1;
        end else if (st_q == S_RUN) begin
            state_q <= mixed ^ rk;
            key_q   <= key_next;
            rnd_q   <= rnd_q + 4'd1;
            if (last_rnd) out_data_q <= shifted ^ rk;
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// Purpose : directed-vector bench for aes_iter_core (AES-128 and AES-256 instances).
// Latency : checks Nr-cycle latency, back-to-back spacing and reset recovery.
// Backpressure: exercises a stalled sink and input isolation during RUN.
module tb_aes_iter_core;
    localparam logic [127:0] KA   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, in_key, out_data;
    logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
    logic [127:0] w_in_data, w_out_data;
    logic [255:0] w_in_key;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    aes_iter_core #(.KEY_BITS(128)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_iter_core #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_key(w_in_key), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_data(w_out_data), .busy(w_busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // present a block at a negedge and return just after its accept edge
    task automatic send(input logic [127:0] k, input logic [127:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_key = k; in_data = d; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 128'(n), 128'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // count cycles after the accept edge until out_valid, and busy cycles seen meanwhile
    task automatic wait_out(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (out_valid) break;
            if (busy) bcnt++;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, errs, t1, t2, n;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_data = '0; w_in_key = '0;

        // reset behaviour
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst256_ready", 128'(w_in_ready), 128'd1);

        // AES-128 FIPS-197 C.1 vector, latency and busy window
        send(KA, PA);
        wait_out(lat, bcnt);
        check("a128_latency", 128'(lat), 128'd10);
        check("a128_busy", 128'(bcnt), 128'd10);
        check("a128_data", out_data, CA);
        check("a128_done_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("a128_hs_valid", 128'(out_valid), 128'd0);
        check("a128_hs_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b0;

        // AES-256 FIPS-197 C.3 vector
        @(negedge clk);
        w_in_key = K256; w_in_data = PA; w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        lat = 0; bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (w_out_valid) break;
            if (w_busy) bcnt++;
            lat++;
        end
        check("a256_latency", 128'(lat), 128'd14);
        check("a256_busy", 128'(bcnt), 128'd14);
        check("a256_data", w_out_data, C256);
        w_out_ready = 1'b1;

        // stalled sink: ciphertext stable, no new block accepted
        send(KB, PB);
        wait_out(lat, bcnt);
        check("bp_data", out_data, CB);
        errs = 0;
        in_valid = 1'b1; in_key = KA; in_data = PA;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_data !== CB || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) errs++;
        end
        check("bp_stall", 128'(errs), 128'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("bp_once", 128'(n), 128'd0);
        check("bp_idle", 128'(in_ready), 128'd1);

        // back-to-back: second block accepted on the edge the first is consumed
        out_ready = 1'b1;
        @(negedge clk);
        in_key = KA; in_data = PA; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_key = KB; in_data = PB;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        t1 = cyc;
        check("b2b_first", out_data, CA);
        check("b2b_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        t2 = cyc;
        check("b2b_second", out_data, CB);
        check("b2b_gap", 128'(t2 - t1), 128'd11);
        @(negedge clk);

        // input isolation: scramble inputs every cycle during RUN
        send(KB, PB);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (out_valid) break;
            in_key  = {$urandom, $urandom, $urandom, $urandom};
            in_data = {$urandom, $urandom, $urandom, $urandom};
            n++;
        end
        check("iso_latency", 128'(n), 128'd10);
        check("iso_data", out_data, CB);
        @(negedge clk);

        // reset while round 5 is pending
        send(KA, PA);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 128'(out_valid), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_ready", 128'(in_ready), 128'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("mid_rst_spurious", 128'(n), 128'd0);
        send(KB, PB);
        wait_out(lat, bcnt);
        check("post_rst_latency", 128'(lat), 128'd10);
        check("post_rst_data", out_data, CB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
